// File: rtl/cpt_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
package cpt_pkg;

  localparam int DEF_DIGIT_WIDTH  = 4;
  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_MODULO_VALUE = 10;

  // Clamp a loaded digit into the legal range 0..modulo-1.
  function automatic logic [31:0] clampDigit(input logic [31:0] val,
                                             input logic [31:0] modulo);
    if (val >= modulo) return modulo - 32'd1;
    return val;
  endfunction

  // Bit position of the LSB of digit idx inside a packed digit vector.
  function automatic int digitLsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cpt_ndigits_mod_if.sv
// Command/status bundle of the cascaded counter.
// With CPT_CAPTURE_EN defined the bundle also carries Capture/CapQ.
interface cpt_ndigits_mod_if
  import cpt_pkg::*;
#(
  parameter int W = DEF_NUM_DIGITS * DEF_DIGIT_WIDTH
);
  logic         En;
  logic         Up;
  logic         Clear;
  logic         Load;
  logic [W-1:0] LoadVal;
  logic [W-1:0] Q;
  logic         TC;
  logic         Overflow;
`ifdef CPT_CAPTURE_EN
  logic         Capture;
  logic [W-1:0] CapQ;

  modport master (output En, Up, Clear, Load, LoadVal, Capture,
                  input  Q, TC, Overflow, CapQ);
  modport slave  (input  En, Up, Clear, Load, LoadVal, Capture,
                  output Q, TC, Overflow, CapQ);
`else
  modport master (output En, Up, Clear, Load, LoadVal,
                  input  Q, TC, Overflow);
  modport slave  (input  En, Up, Clear, Load, LoadVal,
                  output Q, TC, Overflow);
`endif
endinterface

// File: rtl/cpt_digit.sv
// One modulo digit: clear / clamped load / step up or down with wrap.
// Arithmetic is one bit wider than the digit so the wrap test is exact
// even when the modulus equals 2**DIGIT_WIDTH.
module cpt_digit
  import cpt_pkg::*;
#(
  parameter int DIGIT_WIDTH     = DEF_DIGIT_WIDTH,
  parameter int MODULO_VALUE    = DEF_MODULO_VALUE,
  parameter int CLK_ACTIVE_EDGE = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Clear,
  input  logic                   Load,
  input  logic [DIGIT_WIDTH-1:0] LoadDigit,
  input  logic                   Step,
  input  logic                   Up,
  output logic [DIGIT_WIDTH-1:0] Digit,
  output logic                   AtMax,
  output logic                   AtZero
);
  localparam int                   EW    = DIGIT_WIDTH + 1;
  localparam logic [DIGIT_WIDTH-1:0] MAX_D = DIGIT_WIDTH'(MODULO_VALUE - 1);

  logic [EW-1:0]          digitExt;
  logic [EW-1:0]          incExt;
  logic [EW-1:0]          decExt;
  logic [DIGIT_WIDTH-1:0] loadClamped;
  logic [DIGIT_WIDTH-1:0] digitNext;

  assign digitExt    = {1'b0, Digit};
  assign incExt      = digitExt + EW'(1);
  assign decExt      = digitExt - EW'(1);
  assign AtMax       = (Digit == MAX_D);
  assign AtZero      = (Digit == '0);
  assign loadClamped = DIGIT_WIDTH'(clampDigit(32'(LoadDigit), 32'(MODULO_VALUE)));

  // Next digit value: Clear beats Load beats Step; otherwise hold.
  always_comb begin
    digitNext = Digit;
    if (Clear) begin
      digitNext = '0;
    end else if (Load) begin
      digitNext = loadClamped;
    end else if (Step) begin
      if (Up) begin
        digitNext = (incExt == EW'(MODULO_VALUE)) ? '0 : incExt[DIGIT_WIDTH-1:0];
      end else begin
        digitNext = decExt[DIGIT_WIDTH] ? MAX_D : decExt[DIGIT_WIDTH-1:0];
      end
    end
  end

  if (CLK_ACTIVE_EDGE != 0) begin : gRise
    // Digit register on the rising edge, asynchronously cleared.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) Digit <= '0;
      else       Digit <= digitNext;
    end
  end else begin : gFall
    // Digit register on the falling edge, asynchronously cleared.
    always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) Digit <= '0;
      else       Digit <= digitNext;
    end
  end

endmodule

// File: rtl/cpt_ndigits_mod.sv
// Multi-digit cascaded modulo counter (e.g. BCD) with enable, direction,
// clear, clamped parallel load, combinational terminal count and a sticky
// overflow flag. Optional macro CPT_CAPTURE_EN adds a snapshot register
// CapQ that grabs the pre-update count when Capture is high.
module cpt_ndigits_mod
  import cpt_pkg::*;
#(
  parameter int DIGIT_WIDTH     = DEF_DIGIT_WIDTH,
  parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
  parameter int MODULO_VALUE    = DEF_MODULO_VALUE,
  parameter int CLK_ACTIVE_EDGE = 1
) (
  input  logic Clk,
  input  logic Reset,
  cpt_ndigits_mod_if.slave bus
);
  localparam int QW = NUM_DIGITS * DIGIT_WIDTH;

  logic [NUM_DIGITS:0]   carryUp;
  logic [NUM_DIGITS:0]   borrowDn;
  logic [NUM_DIGITS-1:0] atMax;
  logic [NUM_DIGITS-1:0] atZero;
  logic [NUM_DIGITS-1:0] step;
  logic [QW-1:0]         qInt;
  logic                  ovfReg;
  logic                  ovfNext;
  logic                  tcInt;

  // A digit moves only when every lower digit is at its wrap point for
  // the current direction; the chain is rebuilt from Q and Up each cycle.
  assign carryUp[0]  = 1'b1;
  assign borrowDn[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    assign carryUp[i+1]  = carryUp[i]  & atMax[i];
    assign borrowDn[i+1] = borrowDn[i] & atZero[i];
    assign step[i]       = bus.En & (bus.Up ? carryUp[i] : borrowDn[i]);

    cpt_digit #(
      .DIGIT_WIDTH    (DIGIT_WIDTH),
      .MODULO_VALUE   (MODULO_VALUE),
      .CLK_ACTIVE_EDGE(CLK_ACTIVE_EDGE)
    ) uDigit (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear    (bus.Clear),
      .Load     (bus.Load),
      .LoadDigit(bus.LoadVal[digitLsb(i, DIGIT_WIDTH) +: DIGIT_WIDTH]),
      .Step     (step[i]),
      .Up       (bus.Up),
      .Digit    (qInt[digitLsb(i, DIGIT_WIDTH) +: DIGIT_WIDTH]),
      .AtMax    (atMax[i]),
      .AtZero   (atZero[i])
    );
  end

  assign tcInt        = bus.En & (bus.Up ? carryUp[NUM_DIGITS] : borrowDn[NUM_DIGITS]);
  assign bus.TC       = tcInt;
  assign bus.Q        = qInt;
  assign bus.Overflow = ovfReg;

  // Sticky wrap flag: cleared by Clear, frozen during Load, set on a full wrap.
  always_comb begin
    ovfNext = ovfReg;
    if (bus.Clear)      ovfNext = 1'b0;
    else if (bus.Load)  ovfNext = ovfReg;
    else if (tcInt)     ovfNext = 1'b1;
  end

`ifdef CPT_CAPTURE_EN
  logic [QW-1:0] capReg;
  logic [QW-1:0] capNext;

  assign bus.CapQ = capReg;

  // Snapshot takes the count as it stood before this edge's update.
  always_comb begin
    capNext = capReg;
    if (bus.Capture) capNext = qInt;
  end
`endif

  if (CLK_ACTIVE_EDGE != 0) begin : gRegRise
    // Overflow register on the rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) ovfReg <= 1'b0;
      else       ovfReg <= ovfNext;
    end
`ifdef CPT_CAPTURE_EN
    // Capture register on the rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) capReg <= '0;
      else       capReg <= capNext;
    end
`endif
  end else begin : gRegFall
    // Overflow register on the falling edge.
    always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) ovfReg <= 1'b0;
      else       ovfReg <= ovfNext;
    end
`ifdef CPT_CAPTURE_EN
    // Capture register on the falling edge.
    always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) capReg <= '0;
      else       capReg <= capNext;
    end
`endif
  end

endmodule

// File: tb/tb_cpt_ndigits_mod.sv
// Directed bench for cpt_ndigits_mod: a rising-edge BCD instance and a
// falling-edge instance, 4 digits modulo 10.
module tb_cpt_ndigits_mod;
  import cpt_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpt_ndigits_mod_if #(.W(16)) bus ();
  cpt_ndigits_mod_if #(.W(16)) bus2 ();

  cpt_ndigits_mod #(
    .DIGIT_WIDTH(4), .NUM_DIGITS(4), .MODULO_VALUE(10), .CLK_ACTIVE_EDGE(1)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  cpt_ndigits_mod #(
    .DIGIT_WIDTH(4), .NUM_DIGITS(4), .MODULO_VALUE(10), .CLK_ACTIVE_EDGE(0)
  ) dutFall (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.En = 0; bus.Up = 1; bus.Clear = 0; bus.Load = 0; bus.LoadVal = '0;
    bus2.En = 0; bus2.Up = 1; bus2.Clear = 0; bus2.Load = 0; bus2.LoadVal = '0;
`ifdef CPT_CAPTURE_EN
    bus.Capture = 0;
    bus2.Capture = 0;
`endif
    #1;
    check("reset_q", 64'(bus.Q), 64'h0000);
    check("reset_ovf", 64'(bus.Overflow), 64'h0);
`ifdef CPT_CAPTURE_EN
    check("reset_capq", 64'(bus.CapQ), 64'h0000);
`endif
    repeat (2) step();
    rst = 1'b0;

    // Falling-edge instance: nothing happens on the rising edge.
    @(negedge clk); #1;
    bus2.Load = 1; bus2.LoadVal = 16'h0321;
    @(posedge clk); #1;
    check("fall_no_rise_load", 64'(bus2.Q), 64'h0000);
    @(negedge clk); #1;
    check("fall_load", 64'(bus2.Q), 64'h0321);
    bus2.Load = 0; bus2.En = 1; bus2.Up = 1;
    @(posedge clk); #1;
    check("fall_no_rise_count", 64'(bus2.Q), 64'h0321);
    @(negedge clk); #1;
    check("fall_count", 64'(bus2.Q), 64'h0322);
    bus2.En = 0;

    // Asynchronous reset between edges.
    bus.Load = 1; bus.LoadVal = 16'h0357;
    step();
    check("load_0357", 64'(bus.Q), 64'h0357);
    bus.Load = 0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", 64'(bus.Q), 64'h0000);
    check("async_rst_ovf", 64'(bus.Overflow), 64'h0);
    rst = 1'b0;
    bus.En = 1; bus.Up = 1;
    step();
    check("after_rst_count", 64'(bus.Q), 64'h0001);
    bus.En = 0;

    // Carry across several digits.
    bus.Load = 1; bus.LoadVal = 16'h0998;
    step();
    bus.Load = 0; bus.En = 1; bus.Up = 1;
    check("tc_0998", 64'(bus.TC), 64'h0);
    step();
    check("up_0999", 64'(bus.Q), 64'h0999);
    step();
    check("up_1000", 64'(bus.Q), 64'h1000);
    step();
    check("up_1001", 64'(bus.Q), 64'h1001);
    check("ovf_no_wrap", 64'(bus.Overflow), 64'h0);
    bus.En = 0;

    // Full wrap upward.
    bus.Load = 1; bus.LoadVal = 16'h9999;
    step();
    bus.Load = 0;
    check("tc_9999_en0", 64'(bus.TC), 64'h0);
    bus.En = 1; bus.Up = 1;
    #1;
    check("tc_9999_up", 64'(bus.TC), 64'h1);
    step();
    check("wrap_up_q", 64'(bus.Q), 64'h0000);
    check("wrap_up_ovf", 64'(bus.Overflow), 64'h1);
    repeat (5) step();
    check("sticky_q", 64'(bus.Q), 64'h0005);
    check("sticky_ovf", 64'(bus.Overflow), 64'h1);

    // Borrow chain and full wrap downward.
    bus.En = 0; bus.Clear = 1;
    step();
    check("clear_q", 64'(bus.Q), 64'h0000);
    check("clear_ovf", 64'(bus.Overflow), 64'h0);
    bus.Clear = 0; bus.Load = 1; bus.LoadVal = 16'h1000;
    step();
    bus.Load = 0; bus.En = 1; bus.Up = 0;
    step();
    check("down_0999", 64'(bus.Q), 64'h0999);
    check("down_ovf0", 64'(bus.Overflow), 64'h0);
    bus.En = 0; bus.Load = 1; bus.LoadVal = 16'h0000;
    step();
    bus.Load = 0; bus.En = 1; bus.Up = 0;
    #1;
    check("tc_0000_down", 64'(bus.TC), 64'h1);
    step();
    check("wrap_down_q", 64'(bus.Q), 64'h9999);
    check("wrap_down_ovf", 64'(bus.Overflow), 64'h1);
    bus.En = 0; bus.Clear = 1;
    step();
    check("clear2_q", 64'(bus.Q), 64'h0000);
    check("clear2_ovf", 64'(bus.Overflow), 64'h0);

    // Priority and clamping.
    bus.Clear = 1; bus.Load = 1; bus.LoadVal = 16'h1234; bus.En = 1; bus.Up = 1;
    step();
    check("clear_beats_load", 64'(bus.Q), 64'h0000);
    bus.Clear = 0; bus.En = 0; bus.LoadVal = 16'hABCD;
    step();
    check("load_clamp", 64'(bus.Q), 64'h9999);
    bus.Load = 0; bus.En = 1; bus.Up = 1;
    step();
    check("wrap_again_ovf", 64'(bus.Overflow), 64'h1);
    bus.Load = 1; bus.LoadVal = 16'h0042;
    step();
    check("load_beats_en", 64'(bus.Q), 64'h0042);
    check("load_keeps_ovf", 64'(bus.Overflow), 64'h1);

    // Direction changes every cycle.
    bus.Load = 1; bus.LoadVal = 16'h0100; bus.En = 0;
    step();
    bus.Load = 0; bus.En = 1; bus.Up = 0;
    step();
    check("dir_down_0099", 64'(bus.Q), 64'h0099);
    bus.Up = 1;
    step();
    check("dir_up_0100", 64'(bus.Q), 64'h0100);
    bus.En = 0;
    step();
    check("hold", 64'(bus.Q), 64'h0100);

`ifdef CPT_CAPTURE_EN
    bus.Load = 1; bus.LoadVal = 16'h0042;
    step();
    bus.Load = 0; bus.Capture = 1; bus.Clear = 1;
    step();
    check("cap_value", 64'(bus.CapQ), 64'h0042);
    check("cap_clear_q", 64'(bus.Q), 64'h0000);
    bus.Capture = 0; bus.Clear = 0; bus.En = 1; bus.Up = 1;
    step();
    check("cap_hold", 64'(bus.CapQ), 64'h0042);
    check("cap_count_q", 64'(bus.Q), 64'h0001);
    bus.En = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
